input_conditioner: RTL and testbench

Parametrised successor to the board-level button parser. Conditions WIDTH asynchronous inputs (buttons, switches) for the CPU clock domain: multi-stage synchroniser, shared sample-tick debouncer, and a per-channel pulse generator. Each channel is runtime-selectable between press-pulse, release-pulse, level and auto-repeat modes. Instantiated in the board top between the board pins and the CPU/reset logic.

---
 rtl/input_conditioner.sv | 148 ++++++++++++++
 tb/tb_input_conditioner.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Conditions WIDTH asynchronous inputs: synchroniser, shared-tick debouncer and
// a per-channel pulse generator with press/release/level/auto-repeat modes.
module input_conditioner #(
    parameter int WIDTH          = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int SAMPLE_CNT_MAX = 41667,
    parameter int PULSE_CNT_MAX  = 200,
    parameter int REPEAT_DELAY   = 1000,
    parameter int REPEAT_RATE    = 200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in,
    input  logic [2*WIDTH-1:0] mode,
    output logic [WIDTH-1:0]   level,
    output logic [WIDTH-1:0]   pulse
);

    localparam int SCW  = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
    localparam int DCW  = $clog2(PULSE_CNT_MAX + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RCW  = $clog2(RMAX + 1);

    localparam logic [1:0] MODE_PRESS   = 2'b00;
    localparam logic [1:0] MODE_RELEASE = 2'b01;
    localparam logic [1:0] MODE_LEVEL   = 2'b10;
    localparam logic [1:0] MODE_REPEAT  = 2'b11;

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [SCW-1:0]   smp_cnt_q, smp_cnt_d;
    logic [DCW-1:0]   deb_q [WIDTH];
    logic [DCW-1:0]   deb_d [WIDTH];
    logic [RCW-1:0]   rpt_cnt_q [WIDTH];
    logic [RCW-1:0]   rpt_cnt_d [WIDTH];
    rpt_state_t       state_q [WIDTH];
    rpt_state_t       state_d [WIDTH];
    logic [WIDTH-1:0] level_q, level_d, level_dly_q;
    logic [WIDTH-1:0] pulse_q, pulse_d;

    logic       tick;
    logic       rise, fall, rpt_ok, rpt_fire;
    logic [1:0] ch_mode;

    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    always_comb begin
        tick      = (smp_cnt_q == SCW'(SAMPLE_CNT_MAX - 1));
        smp_cnt_d = tick ? '0 : smp_cnt_q + SCW'(1);
        deb_d     = deb_q;
        rpt_cnt_d = rpt_cnt_q;
        state_d   = state_q;
        level_d   = '0;
        pulse_d   = '0;
        rise      = 1'b0;
        fall      = 1'b0;
        rpt_ok    = 1'b0;
        rpt_fire  = 1'b0;
        ch_mode   = MODE_PRESS;

        for (int i = 0; i < WIDTH; i++) begin
            if (tick) begin
                if (!sync_q[SYNC_STAGES-1][i]) begin
                    deb_d[i] = '0;
                end else if (deb_q[i] != DCW'(PULSE_CNT_MAX)) begin
                    deb_d[i] = deb_q[i] + DCW'(1);
                end
            end
            level_d[i] = (deb_d[i] == DCW'(PULSE_CNT_MAX));

            rise     = level_q[i] & ~level_dly_q[i];
            fall     = ~level_q[i] & level_dly_q[i];
            ch_mode  = mode[2*i +: 2];
            rpt_ok   = level_q[i] && (ch_mode == MODE_REPEAT);
            rpt_fire = 1'b0;

            // Losing the level or leaving repeat mode wins over a count-out in the same cycle.
            if (!rpt_ok) begin
                state_d[i]   = IDLE;
                rpt_cnt_d[i] = '0;
            end else begin
                case (state_q[i])
                    IDLE: begin
                        if (rise) begin
                            state_d[i]   = DELAY;
                            rpt_cnt_d[i] = '0;
                        end
                    end
                    DELAY: begin
                        if (rpt_cnt_q[i] == RCW'(REPEAT_DELAY)) begin
                            rpt_fire     = 1'b1;
                            rpt_cnt_d[i] = '0;
                            state_d[i]   = REPEAT;
                        end else if (tick) begin
                            rpt_cnt_d[i] = rpt_cnt_q[i] + RCW'(1);
                        end
                    end
                    REPEAT: begin
                        if (rpt_cnt_q[i] == RCW'(REPEAT_RATE)) begin
                            rpt_fire     = 1'b1;
                            rpt_cnt_d[i] = '0;
                        end else if (tick) begin
                            rpt_cnt_d[i] = rpt_cnt_q[i] + RCW'(1);
                        end
                    end
                    default: state_d[i] = IDLE;
                endcase
            end

            case (ch_mode)
                MODE_PRESS:   pulse_d[i] = rise;
                MODE_RELEASE: pulse_d[i] = fall;
                MODE_LEVEL:   pulse_d[i] = level_q[i];
                default:      pulse_d[i] = rise | rpt_fire;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                deb_q[i]     <= '0;
                rpt_cnt_q[i] <= '0;
                state_q[i]   <= IDLE;
            end
            smp_cnt_q   <= '0;
            level_q     <= '0;
            level_dly_q <= '0;
            pulse_q     <= '0;
        end else begin
            sync_q[0] <= in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            deb_q       <= deb_d;
            rpt_cnt_q   <= rpt_cnt_d;
            state_q     <= state_d;
            smp_cnt_q   <= smp_cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
            pulse_q     <= pulse_d;
        end
    end

    assign level = level_q;
    assign pulse = pulse_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: stimulus pushes expected pulse cycles,
// a negedge monitor compares every pulse the DUT presents against them.
module tb_input_conditioner;

    localparam int WIDTH = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [WIDTH-1:0]   in  = '0;
    logic [2*WIDTH-1:0] mode;
    logic [WIDTH-1:0]   level;
    logic [WIDTH-1:0]   pulse;

    int cyc      = 0;
    int rst_cyc  = 0;
    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int ch;
        int cyc;
    } exp_t;

    exp_t sb[$];

    input_conditioner #(
        .WIDTH(WIDTH), .SYNC_STAGES(2), .SAMPLE_CNT_MAX(4),
        .PULSE_CNT_MAX(3), .REPEAT_DELAY(4), .REPEAT_RATE(2)
    ) dut (
        .clk(clk), .rst(rst), .in(in), .mode(mode), .level(level), .pulse(pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Sample counter restarts at 0 in the cycle of the last reset edge; tick at count 3.
    function automatic bit is_tick(input int c);
        return ((c - rst_cyc) % 4) == 3;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic goto_tick();
        do step(1); while (!is_tick(cyc));
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic push(input int ch, input int c);
        exp_t e;
        e.ch  = ch;
        e.cyc = c;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        bit hit;
        for (int i = 0; i < WIDTH; i++) begin
            hit = 1'b0;
            for (int k = sb.size() - 1; k >= 0; k--) begin
                if (sb[k].ch == i && sb[k].cyc == cyc) begin
                    hit = 1'b1;
                    sb.delete(k);
                end
            end
            if (hit) check($sformatf("pulse%0d_expected", i), 32'(pulse[i]), 32'd1);
            else if (pulse[i] === 1'b1) check($sformatf("pulse%0d_unexpected", i), 32'(pulse[i]), 32'd0);
        end
    end

    initial begin
        int t;
        mode = 8'b11_01_00_00;
        step(3);
        rst_cyc = cyc;
        rst = 1'b0;
        check("reset_level", 32'(level), 32'd0);
        check("reset_pulse", 32'(pulse), 32'd0);

        // Press on ch0: level after 3rd tick seeing 1, one pulse, none on release.
        goto_tick();
        t = cyc;
        in[0] = 1'b1;
        push(0, t + 14);
        wait_until(t + 12); check("t1_level_before", 32'(level[0]), 32'd0);
        wait_until(t + 13); check("t1_level_rise",   32'(level[0]), 32'd1);
        wait_until(t + 24); in[0] = 1'b0;
        wait_until(t + 28); check("t1_level_held",   32'(level[0]), 32'd1);
        wait_until(t + 29); check("t1_level_fall",   32'(level[0]), 32'd0);
        wait_until(t + 40);

        // Bounce on ch1: 2 ticks high, 1 tick low, never saturates.
        goto_tick();
        repeat (5) begin
            in[1] = 1'b1;
            step(8);
            in[1] = 1'b0;
            step(1);
            check("t2_bounce_level", 32'(level[1]), 32'd0);
            step(3);
        end
        step(12);
        check("t2_bounce_final", 32'(level[1]), 32'd0);

        // Release mode on ch2: pulse only after level falls.
        goto_tick();
        t = cyc;
        in[2] = 1'b1;
        push(2, t + 30);
        wait_until(t + 13); check("t3_level_rise", 32'(level[2]), 32'd1);
        wait_until(t + 24); in[2] = 1'b0;
        wait_until(t + 28); check("t3_level_held", 32'(level[2]), 32'd1);
        wait_until(t + 29); check("t3_level_fall", 32'(level[2]), 32'd0);
        wait_until(t + 40);

        // Auto-repeat on ch3: T0, T0+4, +6, +8, +10 ticks, then silence after release.
        goto_tick();
        t = cyc;
        in[3] = 1'b1;
        push(3, t + 14); push(3, t + 30); push(3, t + 38); push(3, t + 46); push(3, t + 54);
        wait_until(t + 13); check("t4_level_rise", 32'(level[3]), 32'd1);
        wait_until(t + 52); in[3] = 1'b0;
        wait_until(t + 57); check("t4_level_fall", 32'(level[3]), 32'd0);
        wait_until(t + 72);

        // Level mode on ch0, press mode on ch1 pressed one tick later, ch1 switched to 11 while held.
        mode[1:0] = 2'b10;
        goto_tick();
        t = cyc;
        in[0] = 1'b1;
        for (int k = 14; k <= 45; k++) push(0, t + k);
        wait_until(t + 4); in[1] = 1'b1;
        push(1, t + 18);
        wait_until(t + 16);
        check("t5_ch0_level", 32'(level[0]), 32'd1);
        check("t5_ch1_level_before", 32'(level[1]), 32'd0);
        wait_until(t + 17); check("t5_ch1_level_rise", 32'(level[1]), 32'd1);
        wait_until(t + 20); mode[3:2] = 2'b11;
        wait_until(t + 40); in[0] = 1'b0; in[1] = 1'b0;
        wait_until(t + 44); check("t5_ch0_level_held", 32'(level[0]), 32'd1);
        wait_until(t + 45); check("t5_levels_fall", 32'(level[1:0]), 32'd0);
        wait_until(t + 60);

        // Reset during REPEAT on ch3 with input held; repeat restarts from DELAY.
        goto_tick();
        t = cyc;
        in[3] = 1'b1;
        push(3, t + 14); push(3, t + 30);
        wait_until(t + 32); rst = 1'b1;
        step(1);
        rst_cyc = cyc;
        rst = 1'b0;
        check("t6_reset_level", 32'(level), 32'd0);
        check("t6_reset_pulse", 32'(pulse), 32'd0);
        push(3, t + 46); push(3, t + 62);
        wait_until(t + 44); check("t6_level_before", 32'(level[3]), 32'd0);
        wait_until(t + 45); check("t6_level_rise",   32'(level[3]), 32'd1);
        wait_until(t + 64); in[3] = 1'b0;
        wait_until(t + 69); check("t6_level_fall",   32'(level[3]), 32'd0);
        wait_until(t + 85);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
